// File: rtl/dmem_line_responder.sv
// -----------------------------------------------------------------------------
// dmem_line_responder
//
// Memory-side model of the data memory that a data cache talks to. It serves
// two kinds of request, each with a fixed latency:
//   - 4-word line refill reads. The line base is MEM_ADDR with bits [1:0]
//     cleared.
//   - byte-enabled single-word writes (write-through traffic).
// The model uses a RDY/VALID handshake. RDY is high while the block can take
// a request. VALID pulses for one cycle after the access has been performed.
//
// Parameters:
//   ADDR_W  - word-address width; the array holds 2**ADDR_W 32-bit words
//   LATENCY - cycles from request acceptance to completion (1..15)
//
// Ports:
//   CLK       clock, rising edge
//   RSTn      asynchronous active-low reset (memory array is not reset)
//   MEM_CSN   active-low request strobe, sampled only while RDY=1
//   MEM_WEN   active-low write select: 0 = word write, 1 = line read
//   MEM_ADDR  word address
//   MEM_BE    byte enables for writes, bit i -> bits [8i+7:8i]
//   MEM_DI    write data
//   LINE_DOUT read line, word g at bits [32g+31:32g]; holds until next read
//   RDY       idle / able to accept a request
//   VALID     one-cycle completion pulse
// -----------------------------------------------------------------------------
module dmem_line_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 6
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              MEM_CSN,
  input  logic              MEM_WEN,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [3:0]        MEM_BE,
  input  logic [31:0]       MEM_DI,
  output logic [127:0]      LINE_DOUT,
  output logic              RDY,
  output logic              VALID
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          DEPTH  = 2 ** ADDR_W;
  localparam bit          BYPASS = (LATENCY == 1);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         di_q, di_d;
  logic [127:0]        line_dout_q, line_dout_d;
  logic                rdy_q, rdy_d;
  logic                valid_q, valid_d;

  // Effective request for the access. With LATENCY=1 the access happens on
  // the acceptance edge itself, so it must use the live inputs rather than
  // the latched copies.
  logic                acc_wen;
  logic [ADDR_W-1:0]   acc_addr;
  logic [3:0]          acc_be;
  logic [31:0]         acc_di;
  logic [ADDR_W-1:0]   line_base;
  logic                do_access;
  logic                mem_we;

  assign acc_wen   = BYPASS ? MEM_WEN  : wen_q;
  assign acc_addr  = BYPASS ? MEM_ADDR : addr_q;
  assign acc_be    = BYPASS ? MEM_BE   : be_q;
  assign acc_di    = BYPASS ? MEM_DI   : di_q;
  assign line_base = {acc_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    be_d        = be_q;
    di_d        = di_q;
    line_dout_d = line_dout_q;
    do_access   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE also accepts a request, which gives back-to-back operation.
        if (!MEM_CSN) begin
          wen_d  = MEM_WEN;
          addr_d = MEM_ADDR;
          be_d   = MEM_BE;
          di_d   = MEM_DI;
          if (BYPASS) begin
            state_d   = ST_DONE;
            do_access = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Inputs are ignored here; requests made while busy are dropped.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = ST_DONE;
          do_access = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mem_we = do_access && !acc_wen;
    if (do_access && acc_wen) begin
      line_dout_d = {mem[{line_base[ADDR_W-1:2], 2'd3}],
                     mem[{line_base[ADDR_W-1:2], 2'd2}],
                     mem[{line_base[ADDR_W-1:2], 2'd1}],
                     mem[line_base]};
    end

    // Outputs are registered and follow the next state.
    rdy_d   = (state_d != ST_BUSY);
    valid_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wen_q       <= 1'b1;
      addr_q      <= '0;
      be_q        <= '0;
      di_q        <= '0;
      line_dout_q <= '0;
      rdy_q       <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      di_q        <= di_d;
      line_dout_q <= line_dout_d;
      rdy_q       <= rdy_d;
      valid_q     <= valid_d;
    end
  end

  // NOTE: the array has no reset. That keeps it a plain RAM. Reset still
  // drops a pending write, because the asynchronous reset clears state_q and
  // so no access can be issued afterwards.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_addr][8*b +: 8] <= acc_di[8*b +: 8];
      end
    end
  end

  assign LINE_DOUT = line_dout_q;
  assign RDY       = rdy_q;
  assign VALID     = valid_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// -----------------------------------------------------------------------------
// Directed bench for dmem_line_responder. It uses two instances:
//   - a LATENCY=6 instance for the main read/write, busy-drop, back-to-back
//     and reset-abort checks
//   - a LATENCY=1 instance for the bypass / one-access-per-cycle stream
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point.
// -----------------------------------------------------------------------------
module tb_dmem_line_responder;

  localparam int AW  = 12;
  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         rst_n;

  // LATENCY=6 instance
  logic         csn, wen;
  logic [AW-1:0] addr;
  logic [3:0]   be;
  logic [31:0]  di;
  logic [127:0] dout;
  logic         rdy, valid;

  // LATENCY=1 instance
  logic         c1_csn, c1_wen;
  logic [AW-1:0] c1_addr;
  logic [3:0]   c1_be;
  logic [31:0]  c1_di;
  logic [127:0] c1_dout;
  logic         c1_rdy, c1_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_line_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
    .CLK(clk), .RSTn(rst_n), .MEM_CSN(csn), .MEM_WEN(wen), .MEM_ADDR(addr),
    .MEM_BE(be), .MEM_DI(di), .LINE_DOUT(dout), .RDY(rdy), .VALID(valid)
  );

  dmem_line_responder #(.ADDR_W(AW), .LATENCY(1)) u_dut1 (
    .CLK(clk), .RSTn(rst_n), .MEM_CSN(c1_csn), .MEM_WEN(c1_wen),
    .MEM_ADDR(c1_addr), .MEM_BE(c1_be), .MEM_DI(c1_di), .LINE_DOUT(c1_dout),
    .RDY(c1_rdy), .VALID(c1_valid)
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the LATENCY=6 instance, then wait for VALID.
  // Returns the number of edges after the acceptance edge until VALID is seen.
  task automatic req6(input logic w, input logic [AW-1:0] a,
                      input logic [3:0] b, input logic [31:0] d,
                      output int edges);
    csn = 1'b0; wen = w; addr = a; be = b; di = d;
    step();
    csn = 1'b1;
    edges = 0;
    while (!valid && edges < 20) begin
      step();
      edges++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    logic exp_hit;

    rst_n = 1'b0;
    csn = 1'b1; wen = 1'b1; addr = '0; be = '0; di = '0;
    c1_csn = 1'b1; c1_wen = 1'b1; c1_addr = '0; c1_be = '0; c1_di = '0;

    // Reset state
    #12;
    check("reset_rdy",   128'(rdy),   128'd1);
    check("reset_valid", 128'(valid), 128'd0);
    check("reset_dout",  dout,        128'd0);
    rst_n = 1'b1;
    step();
    check("idle_rdy", 128'(rdy), 128'd1);

    // 1: four full-word writes, then a line read with unaligned address.
    //    Access occurs LATENCY-1 edges after acceptance.
    req6(1'b0, 12'h040, 4'hF, 32'h11111111, n);
    check("wr40_lat", 128'(n), 128'(LAT - 1));
    check("wr40_rdy_in_done", 128'(rdy), 128'd1);
    req6(1'b0, 12'h041, 4'hF, 32'h22222222, n);
    req6(1'b0, 12'h042, 4'hF, 32'h33333333, n);
    req6(1'b0, 12'h043, 4'hF, 32'h44444444, n);
    step();
    check("back_to_idle_valid", 128'(valid), 128'd0);
    req6(1'b1, 12'h042, 4'h0, 32'h0, n);
    check("rd40_lat", 128'(n), 128'(LAT - 1));
    check("rd40_line", dout,
          128'h44444444_33333333_22222222_11111111);
    step();
    check("dout_holds", dout, 128'h44444444_33333333_22222222_11111111);

    // 2: byte-enable merge
    req6(1'b0, 12'h100, 4'hF, 32'hAABBCCDD, n);
    req6(1'b0, 12'h100, 4'b0101, 32'h11223344, n);
    check("be_write_dout_unchanged", dout,
          128'h44444444_33333333_22222222_11111111);
    req6(1'b0, 12'h100, 4'b0000, 32'hFFFFFFFF, n);
    check("be_zero_valid", 128'(n), 128'(LAT - 1));
    req6(1'b1, 12'h101, 4'h0, 32'h0, n);
    check("be_merge_word0", 128'(dout[31:0]), 128'h0000_0000_AA22CC44);

    // 3: a request while busy is dropped
    step();
    csn = 1'b0; wen = 1'b1; addr = 12'h040;
    step();                                      // accepted
    csn = 1'b1;
    step();
    step();                                      // third cycle after accept
    check("busy_rdy_low", 128'(rdy), 128'd0);
    csn = 1'b0; wen = 1'b0; addr = 12'h040; be = 4'hF; di = 32'hFFFFFFFF;
    step();
    csn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (valid) pulses++;
      step();
    end
    check("busy_one_valid", 128'(pulses), 128'd1);
    req6(1'b1, 12'h040, 4'h0, 32'h0, n);
    check("busy_write_dropped", dout,
          128'h44444444_33333333_22222222_11111111);

    // 4: back-to-back reads with MEM_CSN held low
    step();
    csn = 1'b0; wen = 1'b1; addr = 12'h040;
    step();                                      // first accept = index 0
    addr = 12'h100;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 6) csn = 1'b1;                    // second accepted at edge 6
      exp_hit = (i == 5) || (i == 11);
      check($sformatf("b2b_valid_%0d", i), 128'(valid), 128'(exp_hit));
      check($sformatf("b2b_rdy_%0d", i),   128'(rdy),   128'(exp_hit));
      if (i == 5)
        check("b2b_line1", dout, 128'h44444444_33333333_22222222_11111111);
      if (i == 11)
        check("b2b_line2_w0", 128'(dout[31:0]), 128'h0000_0000_AA22CC44);
    end
    step();
    check("b2b_idle_rdy", 128'(rdy), 128'd1);

    // 5: reset in the middle of a write
    req6(1'b0, 12'h200, 4'hF, 32'h00000000, n);
    step();
    csn = 1'b0; wen = 1'b0; addr = 12'h200; be = 4'hF; di = 32'hDEADBEEF;
    step();                                      // accepted
    csn = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rdy",   128'(rdy),   128'd1);
    check("rst_mid_valid", 128'(valid), 128'd0);
    check("rst_mid_dout",  dout,        128'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("rst_no_late_valid", 128'(valid), 128'd0);
    req6(1'b1, 12'h200, 4'h0, 32'h0, n);
    check("rst_write_dropped", 128'(dout[31:0]), 128'd0);

    // 6: LATENCY=1 stream, one access per cycle
    step();
    check("l1_idle_rdy",   128'(c1_rdy),   128'd1);
    check("l1_idle_valid", 128'(c1_valid), 128'd0);
    c1_csn = 1'b0; c1_wen = 1'b0; c1_be = 4'hF;
    c1_addr = 12'h010; c1_di = 32'hA0A0A0A0;
    step();
    check("l1_w0_valid", 128'(c1_valid), 128'd1);
    check("l1_w0_rdy",   128'(c1_rdy),   128'd1);
    c1_addr = 12'h011; c1_di = 32'hB1B1B1B1;
    step();
    check("l1_w1_valid", 128'(c1_valid), 128'd1);
    c1_addr = 12'h012; c1_di = 32'hC2C2C2C2;
    step();
    c1_addr = 12'h013; c1_di = 32'hD3D3D3D3;
    step();
    check("l1_w3_rdy", 128'(c1_rdy), 128'd1);
    c1_wen = 1'b1; c1_addr = 12'h013;
    step();
    check("l1_rd_valid", 128'(c1_valid), 128'd1);
    check("l1_rd_line", c1_dout,
          128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
    c1_wen = 1'b0; c1_addr = 12'h010; c1_be = 4'b0001; c1_di = 32'h000000FF;
    step();
    check("l1_wr_dout_hold", c1_dout,
          128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
    c1_wen = 1'b1; c1_addr = 12'h012;
    step();
    check("l1_rd2_line", c1_dout,
          128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0FF);
    c1_csn = 1'b1;
    step();
    check("l1_end_valid", 128'(c1_valid), 128'd0);
    check("l1_end_rdy",   128'(c1_rdy),   128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
